// File: rtl/regfile_2r1w_param.sv
// Parametrised 2-read / 1-write register file with byte enables, write-to-read
// bypass, optional hardwired-zero r0 and a per-register busy scoreboard.
module regfile_2r1w_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   Rw,
  input  logic [DATA_W-1:0]   Din,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                re1,
  input  logic [ADDR_W-1:0]   R1,
  input  logic                re2,
  input  logic [ADDR_W-1:0]   R2,
  output logic [DATA_W-1:0]   OUT1,
  output logic [DATA_W-1:0]   OUT2,
  input  logic                busy_set,
  input  logic [ADDR_W-1:0]   busy_addr,
  output logic                busy1,
  output logic                busy2,
  output logic                any_busy
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned NBYTES   = DATA_W / 8;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [DATA_W-1:0]   wmerged;
  logic [DATA_W-1:0]   rd1;
  logic [DATA_W-1:0]   rd2;
  logic                wr_eff;
  logic                set_eff;

  // Merged write word doubles as the bypass value, so partial writes forward correctly.
  always_comb begin
    wr_eff  = wr && !(ZERO_REG && (Rw == '0));
    wmerged = regs[Rw];
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (wr_be[i]) wmerged[8*i +: 8] = Din[8*i +: 8];
    end

    rd1 = regs[R1];
    if (BYPASS && wr_eff && (R1 == Rw)) rd1 = wmerged;
    if (ZERO_REG && (R1 == '0)) rd1 = '0;

    rd2 = regs[R2];
    if (BYPASS && wr_eff && (R2 == Rw)) rd2 = wmerged;
    if (ZERO_REG && (R2 == '0)) rd2 = '0;
  end

  // Clear-by-write first, then set, so a same-edge re-issue leaves the register busy.
  always_comb begin
    set_eff  = busy_set && !(ZERO_REG && (busy_addr == '0));
    busy_nxt = busy;
    if (wr) busy_nxt[Rw] = 1'b0;
    if (set_eff) busy_nxt[busy_addr] = 1'b1;
    if (ZERO_REG) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_eff) begin
      regs[Rw] <= wmerged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OUT1 <= '0;
      OUT2 <= '0;
      busy <= '0;
    end else begin
      if (re1) OUT1 <= rd1;
      if (re2) OUT2 <= rd2;
      busy <= busy_nxt;
    end
  end

  assign busy1    = busy[R1];
  assign busy2    = busy[R2];
  assign any_busy = |busy;

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Directed bench for regfile_2r1w_param: one bypassing and one non-bypassing
// instance driven by identical stimulus, checked against hand-computed values.
module tb_regfile_2r1w_param;

  logic        clk;
  logic        rst;
  logic        wr;
  logic [4:0]  Rw;
  logic [31:0] Din;
  logic [3:0]  wr_be;
  logic        re1, re2;
  logic [4:0]  R1, R2;
  logic        busy_set;
  logic [4:0]  busy_addr;

  logic [31:0] out1_b, out2_b, out1_n, out2_n;
  logic        busy1_b, busy2_b, any_b, busy1_n, busy2_n, any_n;

  int tests = 0;
  int fails = 0;

  regfile_2r1w_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .wr(wr), .Rw(Rw), .Din(Din), .wr_be(wr_be),
    .re1(re1), .R1(R1), .re2(re2), .R2(R2), .OUT1(out1_b), .OUT2(out2_b),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .busy1(busy1_b), .busy2(busy2_b), .any_busy(any_b)
  );

  regfile_2r1w_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst(rst), .wr(wr), .Rw(Rw), .Din(Din), .wr_be(wr_be),
    .re1(re1), .R1(R1), .re2(re2), .R2(R2), .OUT1(out1_n), .OUT2(out2_n),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .busy1(busy1_n), .busy2(busy2_n), .any_busy(any_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; wr = 1'b0; Rw = '0; Din = '0; wr_be = '0;
    re1 = 1'b0; R1 = '0; re2 = 1'b0; R2 = '0; busy_set = 1'b0; busy_addr = '0;

    // Asynchronous reset mid-cycle, with activity that must be ignored.
    #2 rst = 1'b1;
    #1;
    check("rst_out1_async", out1_b, 32'h0);
    check("rst_out2_async", out2_b, 32'h0);
    check("rst_anybusy_async", {31'b0, any_b}, 32'h0);
    wr = 1'b1; Rw = 5'd5; Din = 32'h12345678; wr_be = 4'hF;
    busy_set = 1'b1; busy_addr = 5'd5; re1 = 1'b1; R1 = 5'd5;
    tick();
    tick();
    check("rst_out1_held", out1_b, 32'h0);
    wr = 1'b0; busy_set = 1'b0; re1 = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_busy_ignored", {31'b0, any_b}, 32'h0);
    check("rst_busy1", {31'b0, busy1_b}, 32'h0);
    re1 = 1'b1; R1 = 5'd5;
    tick();
    check("rst_write_ignored", out1_b, 32'h0);

    // Read after write.
    re1 = 1'b0; wr = 1'b1; Rw = 5'd5; Din = 32'hDEADBEEF; wr_be = 4'hF;
    tick();
    wr = 1'b0; re1 = 1'b1; R1 = 5'd5;
    tick();
    check("raw_r5", out1_b, 32'hDEADBEEF);

    // Byte enables.
    re1 = 1'b0; wr = 1'b1; Rw = 5'd7; Din = 32'h11223344; wr_be = 4'hF;
    tick();
    Din = 32'hAABBCCDD; wr_be = 4'b0101;
    tick();
    wr = 1'b0; re1 = 1'b1; R1 = 5'd7;
    tick();
    check("be_r7", out1_b, 32'h11BB33DD);

    // Bypass vs non-bypass, full and partial write.
    re1 = 1'b0; wr = 1'b1; Rw = 5'd3; Din = 32'h1; wr_be = 4'hF;
    tick();
    Din = 32'h55; re1 = 1'b1; R1 = 5'd3;
    tick();
    check("bypass_full", out1_b, 32'h55);
    check("nobypass_full", out1_n, 32'h1);
    Din = 32'hAAAAAAAA; wr_be = 4'b0010; re2 = 1'b1; R2 = 5'd3;
    tick();
    check("bypass_partial1", out1_b, 32'h0000AA55);
    check("bypass_partial2", out2_b, 32'h0000AA55);
    check("nobypass_partial", out2_n, 32'h55);
    wr = 1'b0;
    tick();
    check("after_partial", out1_n, 32'h0000AA55);

    // Zero register: write, busy_set and same-edge read of r0.
    wr = 1'b1; Rw = 5'd0; Din = 32'hFFFFFFFF; wr_be = 4'hF;
    busy_set = 1'b1; busy_addr = 5'd0; R1 = 5'd0; R2 = 5'd0;
    tick();
    check("zero_bypass", out1_b, 32'h0);
    wr = 1'b0; busy_set = 1'b0;
    tick();
    check("zero_out1", out1_b, 32'h0);
    check("zero_out2", out2_b, 32'h0);
    check("zero_busy1", {31'b0, busy1_b}, 32'h0);
    check("zero_anybusy", {31'b0, any_b}, 32'h0);

    // Scoreboard.
    re1 = 1'b0; re2 = 1'b0;
    busy_set = 1'b1; busy_addr = 5'd9;
    tick();
    busy_set = 1'b0; R1 = 5'd9; R2 = 5'd8;
    #1;
    check("sb_busy1_set", {31'b0, busy1_b}, 32'h1);
    check("sb_busy2_other", {31'b0, busy2_b}, 32'h0);
    check("sb_anybusy_set", {31'b0, any_b}, 32'h1);
    wr = 1'b1; Rw = 5'd9; Din = 32'hCAFEF00D; wr_be = 4'h0;
    #1;
    check("sb_no_comb_clear", {31'b0, busy1_b}, 32'h1);
    tick();
    wr = 1'b0;
    check("sb_busy1_cleared", {31'b0, busy1_b}, 32'h0);
    check("sb_anybusy_cleared", {31'b0, any_b}, 32'h0);
    re1 = 1'b1;
    tick();
    check("sb_be0_nodata", out1_b, 32'h0);
    re1 = 1'b0; wr = 1'b1; Rw = 5'd9; Din = 32'h9; wr_be = 4'hF;
    busy_set = 1'b1; busy_addr = 5'd9;
    tick();
    wr = 1'b0; busy_set = 1'b0;
    check("sb_set_wins", {31'b0, busy1_b}, 32'h1);

    // Read hold and dual port.
    wr = 1'b1; Rw = 5'd1; Din = 32'hA; wr_be = 4'hF;
    tick();
    Rw = 5'd2; Din = 32'hB;
    tick();
    wr = 1'b0; re1 = 1'b1; R1 = 5'd1; re2 = 1'b1; R2 = 5'd2;
    tick();
    check("dual_out1", out1_b, 32'hA);
    check("dual_out2", out2_b, 32'hB);
    re1 = 1'b0; re2 = 1'b0; wr = 1'b1; Rw = 5'd1; Din = 32'hC;
    tick();
    wr = 1'b0;
    check("hold_out1", out1_b, 32'hA);
    check("hold_out2", out2_b, 32'hB);
    tick();
    check("hold_out1_again", out1_b, 32'hA);
    re1 = 1'b1;
    tick();
    check("reread_out1", out1_b, 32'hC);
    check("still_hold_out2", out2_b, 32'hB);
    check("busy_r9_before_rst", {31'b0, any_b}, 32'h1);

    // Asynchronous reset during operation.
    re1 = 1'b0;
    rst = 1'b1;
    #1;
    check("rst2_out1", out1_b, 32'h0);
    check("rst2_out2", out2_b, 32'h0);
    check("rst2_anybusy", {31'b0, any_b}, 32'h0);
    #2 rst = 1'b0;
    re1 = 1'b1; R1 = 5'd1;
    tick();
    check("rst2_reg_cleared", out1_b, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w_param.md
Name: regfile_2r1w_param

Overview:
- Parametrised successor to the team's fixed 32x32 register file: NUM_REGS x DATA_W storage, one write port and two independent read ports.
- Adds the following over the fixed version:
  - simultaneous read and write in the same cycle;
  - write-to-read bypass;
  - byte-granular write enables;
  - optional hardwired-zero register 0;
  - a per-register busy scoreboard for hazard detection.
- Sits in the CPU datapath between decode (reads and busy marking) and writeback (write).

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W.
- ZERO_REG, 1, 1: register 0 reads as zero, is never written, and is never busy. 0: register 0 is ordinary.
- BYPASS, 1, 1: a read of the address being written in the same cycle returns the new data. 0: it returns the old contents.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high; clears the register array, busy bits and read outputs.
- wr  in  1  write enable.
- Rw  in  ADDR_W  write address.
- Din  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit i enables Din[8i+7:8i].
- re1  in  1  read enable for port 1.
- R1  in  ADDR_W  read address for port 1.
- re2  in  1  read enable for port 2.
- R2  in  ADDR_W  read address for port 2.
- OUT1  out  DATA_W  registered read data for port 1.
- OUT2  out  DATA_W  registered read data for port 2.
- busy_set  in  1  mark register busy_addr as pending.
- busy_addr  in  ADDR_W  register to mark busy.
- busy1  out  1  combinational busy bit of register R1.
- busy2  out  1  combinational busy bit of register R2.
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Reset (asserted asynchronously at any time, including mid-write):
  - all registers 0, all busy bits 0, OUT1 = OUT2 = 0;
  - busy1 = busy2 = any_busy = 0;
  - a write in flight at reset is discarded.
  - While rst is high, wr, re1, re2 and busy_set are ignored.
- Write (rising edge, wr=1):
  - for each byte i with wr_be[i]=1, Reg[Rw] byte i <= Din byte i; bytes with wr_be[i]=0 are unchanged.
  - wr_be all zero: no data change, but busy is still cleared (see scoreboard).
  - ZERO_REG=1 and Rw=0: no effect.
- Read (rising edge, reX=1):
  - OUTX <= value of Reg[RX]; one-cycle latency.
  - reX=0: OUTX holds its previous value.
  - Reads and writes are independent; both ports may read the same address.
- Bypass (BYPASS=1; reX=1, wr=1, RX==Rw, and not (ZERO_REG=1 and RX=0)):
  - OUTX gets the merged word: Din bytes where wr_be=1, old register bytes elsewhere.
  - BYPASS=0: OUTX gets the pre-write contents.
- Zero register (ZERO_REG=1): a read of address 0 always yields 0.
- Busy scoreboard, per register, applied in this order on each edge:
  - wr=1 clears busy[Rw];
  - then busy_set=1 sets busy[busy_addr].
  - busy_set and wr to the same address in the same cycle: busy ends at 1 (set wins; a new producer was issued).
  - ZERO_REG=1: busy[0] is constantly 0, and busy_set to address 0 is ignored.
  - busy1 = busy[R1] and busy2 = busy[R2], combinational from current state, with no bypass of same-cycle set or clear.
- There are no illegal addresses; every address in [0, NUM_REGS-1] is valid.

Test Plan:
1. Reset and read-after-write:
   - Stimulus: assert rst mid-cycle; release; write 0xDEADBEEF to r5 with wr_be=4'hF; next cycle re1=1, R1=5.
   - Required: OUT1=0 during reset; OUT1=0xDEADBEEF one cycle after the read edge.
2. Byte enables:
   - Stimulus: r7=0x11223344; write Din=0xAABBCCDD with wr_be=4'b0101; read r7.
   - Required: OUT1=0x11BB33DD.
3. Bypass and non-bypass:
   - Stimulus: r3=0x1; same edge wr=1, Rw=3, Din=0x55, wr_be=4'hF, re1=1, R1=3.
   - Required: OUT1=0x55 with BYPASS=1; OUT1=0x1 with BYPASS=0.
4. Zero register:
   - Stimulus: ZERO_REG=1; write 0xFFFF_FFFF to r0; busy_set to r0; read r0 on both ports.
   - Required: OUT1=OUT2=0, busy1=0, any_busy=0.
5. Scoreboard:
   - Stimulus: busy_set r9, then R1=9.
   - Required: busy1=1 and any_busy=1.
   - Stimulus: wr to r9.
   - Required: busy1=0 the next cycle.
   - Stimulus: same-edge busy_set and wr to r9.
   - Required: busy1 stays 1.
6. Read hold and dual port:
   - Stimulus: r1=0xA, r2=0xB; read R1=1, R2=2; then re1=re2=0 while writing r1=0xC.
   - Required: OUT1 holds 0xA and OUT2 holds 0xB until the next enabled read.
